knn_sort_core: RTL

Parametrised k-nearest-neighbour engine for the KNN peripheral. It latches one test point and streams training points in through a valid/ready handshake. Squared Euclidean distances are computed in a pipeline, and the K nearest are kept in a sorted on-chip list. On request, a vote state machine returns the majority label. It sits behind the software register file, replacing the fixed 10-neighbour, 2-D core with configurable dimension, width, K and label count.

---
 rtl/knn_sort_core.sv | 222 ++++++++++++++++++++++
 1 files changed

// File: rtl/knn_sort_core.sv
// K-nearest-neighbour engine: pipelined squared distance, sorted K-entry list,
// and a majority-vote FSM over the stored labels.
module knn_sort_core #(
    parameter  int N_DIM    = 2,
    parameter  int COORD_W  = 8,
    parameter  int LABEL_W  = 2,
    parameter  int K        = 10,
    localparam int N_LABELS = 2**LABEL_W,
    localparam int DIST_W   = 2*COORD_W + $clog2(N_DIM) + 1,
    localparam int CNT_W    = $clog2(K+1),
    localparam int IDX_W    = (K > 1) ? $clog2(K) : 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     test_load,
    input  logic [N_DIM*COORD_W-1:0] test_point,
    input  logic                     train_valid,
    output logic                     train_ready,
    input  logic [N_DIM*COORD_W-1:0] train_point,
    input  logic [LABEL_W-1:0]       train_label,
    input  logic                     classify,
    output logic                     busy,
    output logic                     class_valid,
    output logic [LABEL_W-1:0]       class_label,
    output logic                     class_empty,
    output logic [CNT_W-1:0]         count,
    input  logic [IDX_W-1:0]         rd_idx,
    output logic [DIST_W-1:0]        rd_dist,
    output logic [LABEL_W-1:0]       rd_label,
    output logic                     rd_valid
);

    typedef enum logic [2:0] {IDLE, DRAIN, COUNT, ARGMAX, DONE} state_t;
    state_t state;

    logic                     idle, accept, clear;
    logic [N_DIM*COORD_W-1:0] test_reg;

    logic [COORD_W-1:0]       ca, cb, cd;
    logic [2*COORD_W-1:0]     sq_c  [N_DIM];
    logic [2*COORD_W-1:0]     s1_sq [N_DIM];
    logic                     s1_vld, s2_vld;
    logic [LABEL_W-1:0]       s1_lab, s2_lab;
    logic [DIST_W-1:0]        sum_c, s2_dist;

    logic [DIST_W-1:0]        l_dist [K];
    logic [LABEL_W-1:0]       l_lab  [K];
    logic [K-1:0]             l_vld;
    logic [K-1:0]             gt;

    logic [CNT_W-1:0]         votes [N_LABELS];
    logic [IDX_W-1:0]         slot_idx;
    logic [LABEL_W-1:0]       lab_idx, best, next_best;
    logic [CNT_W-1:0]         best_cnt;
    logic                     drain_cnt;

    assign idle        = (state == IDLE);
    assign train_ready = idle && !test_load;
    assign accept      = train_valid && train_ready;
    assign clear       = test_load && idle;
    assign busy        = !idle;

    always_comb begin
        ca = '0;
        cb = '0;
        cd = '0;
        for (int unsigned i = 0; i < N_DIM; i++) begin
            ca = test_reg[i*COORD_W +: COORD_W];
            cb = train_point[i*COORD_W +: COORD_W];
            cd = (ca >= cb) ? ca - cb : cb - ca;
            sq_c[i] = {{COORD_W{1'b0}}, cd} * {{COORD_W{1'b0}}, cd};
        end
    end

    always_comb begin
        sum_c = '0;
        for (int unsigned i = 0; i < N_DIM; i++)
            sum_c = sum_c + DIST_W'(s1_sq[i]);
    end

    // gt[i]: slot i is empty or strictly farther; monotone because the list is sorted and compact
    always_comb begin
        for (int unsigned i = 0; i < K; i++)
            gt[i] = !(l_vld[i] && (l_dist[i] <= s2_dist));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_vld  <= 1'b0;
            s2_vld  <= 1'b0;
            s1_lab  <= '0;
            s2_lab  <= '0;
            s2_dist <= '0;
            for (int unsigned i = 0; i < N_DIM; i++) s1_sq[i] <= '0;
        end else begin
            s1_vld  <= clear ? 1'b0 : accept;
            s2_vld  <= clear ? 1'b0 : s1_vld;
            s2_dist <= sum_c;
            s2_lab  <= s1_lab;
            if (accept) begin
                s1_lab <= train_label;
                for (int unsigned i = 0; i < N_DIM; i++) s1_sq[i] <= sq_c[i];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            test_reg <= '0;
            l_vld    <= '0;
            count    <= '0;
            for (int unsigned i = 0; i < K; i++) begin
                l_dist[i] <= '0;
                l_lab[i]  <= '0;
            end
        end else if (clear) begin
            test_reg <= test_point;
            l_vld    <= '0;
            count    <= '0;
        end else if (s2_vld && gt[K-1]) begin
            if (gt[0]) begin
                l_dist[0] <= s2_dist;
                l_lab[0]  <= s2_lab;
                l_vld[0]  <= 1'b1;
            end
            for (int unsigned i = 1; i < K; i++) begin
                if (gt[i]) begin
                    if (!gt[i-1]) begin
                        l_dist[i] <= s2_dist;
                        l_lab[i]  <= s2_lab;
                        l_vld[i]  <= 1'b1;
                    end else begin
                        l_dist[i] <= l_dist[i-1];
                        l_lab[i]  <= l_lab[i-1];
                        l_vld[i]  <= l_vld[i-1];
                    end
                end
            end
            if (count != CNT_W'(K)) count <= count + 1'b1;
        end
    end

    assign next_best = (votes[lab_idx] > best_cnt) ? lab_idx : best;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            class_valid <= 1'b0;
            class_label <= '0;
            class_empty <= 1'b0;
            slot_idx    <= '0;
            lab_idx     <= '0;
            best        <= '0;
            best_cnt    <= '0;
            drain_cnt   <= 1'b0;
            for (int unsigned i = 0; i < N_LABELS; i++) votes[i] <= '0;
        end else begin
            case (state)
                IDLE: begin
                    class_valid <= 1'b0;
                    if (classify) begin
                        state     <= DRAIN;
                        drain_cnt <= 1'b0;
                    end
                end
                DRAIN: begin
                    for (int unsigned i = 0; i < N_LABELS; i++) votes[i] <= '0;
                    drain_cnt <= 1'b1;
                    if (drain_cnt) begin
                        state    <= COUNT;
                        slot_idx <= '0;
                    end
                end
                COUNT: begin
                    if (l_vld[slot_idx])
                        votes[l_lab[slot_idx]] <= votes[l_lab[slot_idx]] + 1'b1;
                    if (slot_idx == IDX_W'(K-1)) begin
                        state    <= ARGMAX;
                        lab_idx  <= '0;
                        best     <= '0;
                        best_cnt <= '0;
                    end else begin
                        slot_idx <= slot_idx + 1'b1;
                    end
                end
                ARGMAX: begin
                    if (votes[lab_idx] > best_cnt) begin
                        best     <= lab_idx;
                        best_cnt <= votes[lab_idx];
                    end
                    if (lab_idx == '1) begin
                        state       <= DONE;
                        class_valid <= 1'b1;
                        class_empty <= (count == '0);
                        class_label <= (count == '0) ? '0 : next_best;
                    end else begin
                        lab_idx <= lab_idx + 1'b1;
                    end
                end
                DONE: begin
                    class_valid <= 1'b0;
                    state       <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        rd_dist  = '0;
        rd_label = '0;
        rd_valid = 1'b0;
        for (int unsigned i = 0; i < K; i++) begin
            if (rd_idx == IDX_W'(i)) begin
                rd_dist  = l_dist[i];
                rd_label = l_lab[i];
                rd_valid = l_vld[i];
            end
        end
    end

endmodule
